// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the accumulator-ALU command driver.
//                Opcode encodings (ALU CTR), the ALU pipeline latency, the
//                opcode legality check and the driver FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

  localparam int OP_W        = 4;
  localparam int ALU_LATENCY = 2;  // accumulator register + output register

  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND = 4'b1000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_XOR = 4'b1010;
  localparam logic [OP_W-1:0] OP_RSV = 4'b1011;  // ALU output undefined
  localparam logic [OP_W-1:0] OP_SHR = 4'b1100;
  localparam logic [OP_W-1:0] OP_SHL = 4'b1101;
  localparam logic [OP_W-1:0] OP_ROR = 4'b1110;
  localparam logic [OP_W-1:0] OP_ROL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // OP_RSV is rejected because the ALU result is undefined for it; every
  // other unlisted code is rejected because the ALU just returns zero.
  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_XOR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_driver
//  Description : Command-side master for the 8-bit accumulator ALU. Accepts
//                {a, b, op} commands over valid/ready, holds the ALU inputs
//                stable across the ALU pipeline latency, captures O and
//                returns it over a response valid/ready handshake.
//  Ports       : ck, rst            - clock, synchronous active-high reset
//                cmd_valid/ready    - command handshake
//                cmd_a/b/op         - command operands and opcode
//                alu_a/b/ctr        - registered drive into the ALU
//                alu_o              - ALU result
//                rsp_valid/ready    - response handshake
//                rsp_data/err       - captured result / illegal-opcode flag
//                txn_count          - completed responses, wraps 255->0
//  Revision    : 1.0  initial release
// ============================================================================
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int OPW     = OP_W,
  parameter int LATENCY = ALU_LATENCY
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_ctr,
  input  logic [WIDTH-1:0] alu_o,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [7:0]       txn_count
);

  localparam int              CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_pend;   // legality result of the in-flight command
  logic             accept;
  logic             rsp_fire;
  logic             capture;

  // --------------------------------------------------------------------------
  // Next-state and handshake decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    capture   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // Accepting a new command is only possible while the current response
        // is being consumed, so both handshakes can share one edge.
        cmd_ready = rsp_ready;
        if (rsp_ready) state_nxt = cmd_valid ? ST_ISSUE : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Reset wins over any handshake in the same cycle.
    if (rst) cmd_ready = 1'b0;
  end

  assign accept   = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // --------------------------------------------------------------------------
  // Datapath: ALU drive, latency counter, response capture, transaction count
  // --------------------------------------------------------------------------
  always_ff @(posedge ck) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctr   <= '0;
      err_pend  <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      txn_count <= 8'd0;
    end else begin
      // The ALU recomputes every cycle, so its inputs only move on accept.
      if (accept) begin
        alu_a    <= cmd_a;
        alu_b    <= cmd_b;
        alu_ctr  <= cmd_op;
        err_pend <= ~op_is_legal(cmd_op);
      end

      if (state == ST_ISSUE) begin
        wait_cnt <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      // Illegal opcodes return zero so an undefined ALU output never leaks.
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= err_pend ? '0 : alu_o;
        rsp_err   <= err_pend;
      end else if (rsp_fire) begin
        rsp_valid <= 1'b0;
      end

      if (rsp_fire) txn_count <= txn_count + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_driver
//  Description : Self-checking bench for alu_cmd_driver. A behavioural
//                two-register ALU closes the loop; a scoreboard queue holds
//                the expected response of every accepted command, and a
//                vector table plus hand sequences cover timing corners.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  logic             ck = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [OPW-1:0]   cmd_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [OPW-1:0]   alu_ctr;
  logic [WIDTH-1:0] alu_o;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic [7:0]       txn_count;

  always #5 ck = ~ck;

  alu_cmd_driver #(.WIDTH(WIDTH), .OPW(OPW), .LATENCY(2)) dut (
    .ck        (ck),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_ctr   (alu_ctr),
    .alu_o     (alu_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .txn_count (txn_count)
  );

  // ---------------- ALU model: result register then output register -------
  function automatic logic [7:0] alu_func(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SHR:  return {1'b0, a[7:1]};
      OP_SHL:  return {a[6:0], 1'b0};
      OP_ROR:  return {a[0], a[7:1]};
      OP_ROL:  return {a[6:0], a[7]};
      OP_RSV:  return 8'hA5;           // stands in for an undefined result
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0] acc_r = 8'h00;
  logic [7:0] o_r   = 8'h00;
  always @(posedge ck) begin
    acc_r <= alu_func(alu_a, alu_b, alu_ctr);
    o_r   <= acc_r;
  end
  assign alu_o = o_r;

  // ---------------- checking ----------------
  int tests_run = 0;
  int fails     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } exp_t;

  function automatic exp_t expect_rsp(input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] op);
    exp_t e;
    e.err  = ~op_is_legal(op);
    e.data = e.err ? 8'h00 : alu_func(a, b, op);
    return e;
  endfunction

  exp_t sb[$];

  // Handshakes are decided by the values visible at the negedge before the
  // edge that completes them.
  always @(negedge ck) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_data", {24'd0, rsp_data}, {24'd0, e.data});
          check("sb_err",  {31'd0, rsp_err},  {31'd0, e.err});
        end
      end
      if (cmd_valid && cmd_ready) sb.push_back(expect_rsp(cmd_a, cmd_b, cmd_op));
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] exp_d;
    logic       exp_e;
  } vec_t;

  vec_t       vecs[12];
  logic [3:0] legal_ops[9];

  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         output logic [7:0] d, output logic e, output logic ok);
    d = 8'h00;
    e = 1'b0;
    @(posedge ck); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op; rsp_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge ck); #1;
    cmd_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge ck);
        if (rsp_valid) begin ok = 1'b1; d = rsp_data; e = rsp_err; break; end
      end
    end
  endtask

  task automatic rand_cmd();
    cmd_a  = 8'($urandom);
    cmd_b  = 8'($urandom);
    cmd_op = legal_ops[$urandom_range(0, 8)];
  endtask

  logic [7:0] got_d;
  logic       got_e;
  logic       ok;
  logic       acc_seen;
  int         exp_txn;
  int         seen;
  int         n, cyc, last, bad;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h10, 8'h20, OP_SUB, 8'hF0, 1'b0};
    vecs[1]  = '{8'h81, 8'h00, OP_ROL, 8'h03, 1'b0};
    vecs[2]  = '{8'h81, 8'h00, OP_ROR, 8'hC0, 1'b0};
    vecs[3]  = '{8'h12, 8'h34, 4'b0010, 8'h00, 1'b1};
    vecs[4]  = '{8'h12, 8'h34, OP_RSV, 8'h00, 1'b1};
    vecs[5]  = '{8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0};
    vecs[6]  = '{8'hF0, 8'h3C, OP_OR,  8'hFC, 1'b0};
    vecs[7]  = '{8'hF0, 8'h3C, OP_XOR, 8'hCC, 1'b0};
    vecs[8]  = '{8'h81, 8'h00, OP_SHR, 8'h40, 1'b0};
    vecs[9]  = '{8'h81, 8'h00, OP_SHL, 8'h02, 1'b0};
    vecs[10] = '{8'hFF, 8'h01, OP_ADD, 8'h00, 1'b0};
    vecs[11] = '{8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0};
    legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHR, OP_SHL, OP_ROR, OP_ROL};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    exp_txn = 0;

    // ---- reset state ----
    repeat (3) @(posedge ck);
    @(negedge ck);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data",  {24'd0, rsp_data},  32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_alu_a",     {24'd0, alu_a},     32'd0);
    check("rst_alu_b",     {24'd0, alu_b},     32'd0);
    check("rst_alu_ctr",   {28'd0, alu_ctr},   32'd0);
    check("rst_txn_count", {24'd0, txn_count}, 32'd0);
    @(posedge ck); #1 rst = 1'b0;
    @(negedge ck);
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // ---- add: exact response timing ----
    @(posedge ck); #1;
    cmd_valid = 1'b1; cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = OP_ADD;
    @(negedge ck);
    check("add_accept_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge ck); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge ck);
      check($sformatf("add_rsp_valid_cyc%0d", k), {31'd0, rsp_valid}, (k == 4) ? 32'd1 : 32'd0);
    end
    check("add_rsp_data", {24'd0, rsp_data}, 32'h46);
    check("add_rsp_err",  {31'd0, rsp_err},  32'd0);
    @(posedge ck);
    exp_txn++;
    @(negedge ck);
    check("add_rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("add_txn_count", {24'd0, txn_count}, 32'd1);

    // ---- table-driven single commands ----
    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].a, vecs[i].b, vecs[i].op, got_d, got_e, ok);
      check($sformatf("vec%0d_done", i), {31'd0, ok},    32'd1);
      check($sformatf("vec%0d_data", i), {24'd0, got_d}, {24'd0, vecs[i].exp_d});
      check($sformatf("vec%0d_err",  i), {31'd0, got_e}, {31'd0, vecs[i].exp_e});
      exp_txn++;
    end
    @(posedge ck);
    @(negedge ck);
    check("table_txn_count", {24'd0, txn_count}, exp_txn);

    // ---- backpressure: response held, no new command, then same-cycle accept
    @(posedge ck); #1;
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_a = 8'h22; cmd_b = 8'h11; cmd_op = OP_ADD;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ck);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge ck); #1 cmd_valid = 1'b0;
    for (int i = 0; i < 20 && ok; i++) begin
      @(negedge ck);
      if (rsp_valid) break;
    end
    check("bp_first_rsp", {31'd0, rsp_valid}, 32'd1);
    @(posedge ck); #1;
    cmd_valid = 1'b1; cmd_a = 8'h05; cmd_b = 8'h03; cmd_op = OP_SUB;
    for (int k = 0; k < 5; k++) begin
      @(negedge ck);
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data",  {24'd0, rsp_data},  32'h33);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_alu_a",     {24'd0, alu_a},     32'h22);
      if (k < 4) @(posedge ck);
    end
    @(posedge ck); #1 rsp_ready = 1'b1;
    @(negedge ck);
    check("bp_release_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge ck); #1 cmd_valid = 1'b0;
    exp_txn++;
    @(negedge ck);
    check("bp_new_alu_a",   {24'd0, alu_a},     32'h05);
    check("bp_new_alu_ctr", {28'd0, alu_ctr},   {28'd0, OP_SUB});
    check("bp_valid_drop",  {31'd0, rsp_valid}, 32'd0);
    check("bp_txn_count",   {24'd0, txn_count}, exp_txn);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      @(negedge ck);
    end
    check("bp_second_rsp", {31'd0, ok}, 32'd1);
    check("bp_second_data", {24'd0, rsp_data}, 32'h02);
    repeat (3) @(posedge ck);

    // ---- reset while a command is in WAIT ----
    #1;
    cmd_valid = 1'b1; cmd_a = 8'h01; cmd_b = 8'h02; cmd_op = OP_ADD; rsp_ready = 1'b1;
    @(posedge ck); #1 cmd_valid = 1'b0;   // accepted here (IDLE)
    @(posedge ck); #1 rst = 1'b1;         // now in WAIT
    @(posedge ck); #1 rst = 1'b0;
    @(negedge ck);
    check("wrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("wrst_alu_a",     {24'd0, alu_a},     32'd0);
    check("wrst_alu_ctr",   {28'd0, alu_ctr},   32'd0);
    check("wrst_txn_count", {24'd0, txn_count}, 32'd0);
    check("wrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      @(negedge ck);
      if (rsp_valid) seen++;
    end
    check("wrst_no_rsp", seen, 32'd0);
    run_cmd(8'h05, 8'h06, OP_ADD, got_d, got_e, ok);
    check("wrst_next_done", {31'd0, ok},    32'd1);
    check("wrst_next_data", {24'd0, got_d}, 32'h0B);
    check("wrst_next_err",  {31'd0, got_e}, 32'd0);
    @(posedge ck);
    @(negedge ck);
    check("wrst_next_txn", {24'd0, txn_count}, 32'd1);

    // ---- back-to-back stream of 300 legal commands ----
    @(posedge ck); #1 rst = 1'b1;
    repeat (2) @(posedge ck);
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    rand_cmd();
    cmd_valid = 1'b1;
    n = 0; cyc = 0; last = 0; bad = 0;
    while (n < 300 && cyc < 3000) begin
      @(negedge ck);
      acc_seen = cmd_valid && cmd_ready;
      @(posedge ck);
      cyc++;
      if (acc_seen) begin
        if (n > 0 && (cyc - last) != 4) bad++;
        last = cyc;
        n++;
        #1;
        if (n < 300) rand_cmd();
        else         cmd_valid = 1'b0;
      end
    end
    check("stream_count", n, 32'd300);
    check("stream_bad_intervals", bad, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (sb.size() == 0 && !rsp_valid) break;
    end
    check("stream_sb_empty", sb.size(), 32'd0);
    check("stream_txn_count", {24'd0, txn_count}, 32'h2C);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
`default_nettype wire
